// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter
//  Description : Round-robin arbiter that shares the single register-file
//                write port between NUM_SRC writeback sources.
//                Source 0 is ALU/execute, source 1 is LSU load return and
//                source 2 is MUL/DIV. A registered output stage drives the
//                RF write port. A per-register busy scoreboard tracks
//                long-latency destinations so that decode can stall on
//                RAW/WAW hazards.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              : clock
//    rst_n            : synchronous, active-low reset
//    src_valid_i      : per-source writeback pending
//    src_ready_o      : per-source grant (one-hot or zero, combinational)
//    src_rd_addr_i    : packed destination addresses, source 0 in the LSBs
//    src_rd_data_i    : packed write data, source 0 in the LSBs
//    sb_set_i         : long-latency op issued, mark sb_set_addr_i busy
//    sb_set_addr_i    : destination of the issued long-latency op
//    idu_rs1_addr_i   : decode rs1 query
//    idu_rs2_addr_i   : decode rs2 query
//    idu_rd_addr_i    : decode rd query
//    idu_stall_o      : any queried register is busy
//    wb2rf_wr_req_o   : RF write enable
//    wb2rf_rd_addr_o  : RF write address
//    wb2rf_rd_data_o  : RF write data
// ============================================================================
module rf_wb_arbiter #(
    parameter int XLEN      = 32,
    parameter int RF_AWIDTH = 5,
    parameter int RF_SIZE   = 32,
    parameter int NUM_SRC   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC-1:0]             src_valid_i,
    output logic [NUM_SRC-1:0]             src_ready_o,
    input  logic [NUM_SRC*RF_AWIDTH-1:0]   src_rd_addr_i,
    input  logic [NUM_SRC*XLEN-1:0]        src_rd_data_i,
    input  logic                           sb_set_i,
    input  logic [RF_AWIDTH-1:0]           sb_set_addr_i,
    input  logic [RF_AWIDTH-1:0]           idu_rs1_addr_i,
    input  logic [RF_AWIDTH-1:0]           idu_rs2_addr_i,
    input  logic [RF_AWIDTH-1:0]           idu_rd_addr_i,
    output logic                           idu_stall_o,
    output logic                           wb2rf_wr_req_o,
    output logic [RF_AWIDTH-1:0]           wb2rf_rd_addr_o,
    output logic [XLEN-1:0]                wb2rf_rd_data_o
);

    localparam int C_PTR_W      = $clog2(NUM_SRC);
    localparam int C_ADDR_SPACE = 1 << RF_AWIDTH;

    logic [C_PTR_W-1:0]   r_rr_ptr;
    logic [RF_SIZE-1:0]   r_busy;
    logic                 r_wr_req;
    logic [RF_AWIDTH-1:0] r_wr_addr;
    logic [XLEN-1:0]      r_wr_data;

    logic [RF_AWIDTH-1:0] w_src_addr [NUM_SRC];
    logic [XLEN-1:0]      w_src_data [NUM_SRC];

    logic                 w_gnt_any;
    logic [C_PTR_W-1:0]   w_gnt_idx;
    logic [C_PTR_W-1:0]   w_ptr_nxt;
    logic [C_PTR_W-1:0]   w_scan_idx;
    int                   w_scan_sum;
    logic [C_ADDR_SPACE-1:0] w_busy_full;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src_unpack
            assign w_src_addr[gi] = src_rd_addr_i[gi*RF_AWIDTH +: RF_AWIDTH];
            assign w_src_data[gi] = src_rd_data_i[gi*XLEN +: XLEN];
        end
    endgenerate

    // Scan from rr_ptr upwards with wrap; the first valid source wins.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_scan_sum = 0;
        w_scan_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_scan_sum = int'(r_rr_ptr) + k;
            if (w_scan_sum >= NUM_SRC) begin
                w_scan_sum = w_scan_sum - NUM_SRC;
            end
            w_scan_idx = C_PTR_W'(w_scan_sum);
            if (!w_gnt_any && src_valid_i[w_scan_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan_idx;
            end
        end
        // No grants are issued while reset is held.
        if (!rst_n) begin
            w_gnt_any = 1'b0;
        end
    end

    always_comb begin
        w_ptr_nxt = r_rr_ptr;
        if (w_gnt_any) begin
            if (int'(w_gnt_idx) == NUM_SRC - 1) begin
                w_ptr_nxt = '0;
            end else begin
                w_ptr_nxt = w_gnt_idx + 1'b1;
            end
        end
    end

    assign src_ready_o = w_gnt_any ? (NUM_SRC'(1) << w_gnt_idx) : '0;

    // Registered write stage; a grant to x0 is consumed but never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_wr_req  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_rr_ptr <= w_ptr_nxt;
            if (w_gnt_any) begin
                r_wr_req  <= (w_src_addr[w_gnt_idx] != '0);
                r_wr_addr <= w_src_addr[w_gnt_idx];
                r_wr_data <= w_src_data[w_gnt_idx];
            end else begin
                r_wr_req  <= 1'b0;
            end
        end
    end

    // Busy scoreboard: cleared with the RF commit, set by issue. The set is
    // written last so a same-edge set/clear leaves the register busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy[0] <= 1'b0;
            for (int r = 1; r < RF_SIZE; r++) begin
                if (r_wr_req && (r_wr_addr == RF_AWIDTH'(r))) begin
                    r_busy[r] <= 1'b0;
                end
                if (sb_set_i && (sb_set_addr_i == RF_AWIDTH'(r))) begin
                    r_busy[r] <= 1'b1;
                end
            end
        end
    end

    // Widen to the full address space so any query address indexes safely.
    assign w_busy_full = C_ADDR_SPACE'(r_busy);

    assign idu_stall_o = w_busy_full[idu_rs1_addr_i]
                       | w_busy_full[idu_rs2_addr_i]
                       | w_busy_full[idu_rd_addr_i];

    assign wb2rf_wr_req_o  = r_wr_req;
    assign wb2rf_rd_addr_o = r_wr_addr;
    assign wb2rf_rd_data_o = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wb_arbiter
//  Description : Self-checking bench for rf_wb_arbiter. Directed scenarios
//                followed by randomized traffic, all compared against a
//                behavioural model of arbitration, write stage and
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int XLEN      = 32;
    localparam int RF_AWIDTH = 5;
    localparam int RF_SIZE   = 32;
    localparam int NUM_SRC   = 3;

    logic                         clk;
    logic                         rst_n;
    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC-1:0]           src_ready;
    logic [NUM_SRC*RF_AWIDTH-1:0] addr_p;
    logic [NUM_SRC*XLEN-1:0]      data_p;
    logic                         sb_set;
    logic [RF_AWIDTH-1:0]         sb_addr;
    logic [RF_AWIDTH-1:0]         rs1, rs2, rd;
    logic                         stall;
    logic                         wr_req;
    logic [RF_AWIDTH-1:0]         wr_addr;
    logic [XLEN-1:0]              wr_data;

    rf_wb_arbiter #(
        .XLEN(XLEN), .RF_AWIDTH(RF_AWIDTH), .RF_SIZE(RF_SIZE), .NUM_SRC(NUM_SRC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_valid_i    (src_valid),
        .src_ready_o    (src_ready),
        .src_rd_addr_i  (addr_p),
        .src_rd_data_i  (data_p),
        .sb_set_i       (sb_set),
        .sb_set_addr_i  (sb_addr),
        .idu_rs1_addr_i (rs1),
        .idu_rs2_addr_i (rs2),
        .idu_rd_addr_i  (rd),
        .idu_stall_o    (stall),
        .wb2rf_wr_req_o (wr_req),
        .wb2rf_rd_addr_o(wr_addr),
        .wb2rf_rd_data_o(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int                   m_ptr;
    logic [RF_SIZE-1:0]   m_busy;
    logic                 m_wr;
    logic [RF_AWIDTH-1:0] m_addr;
    logic [XLEN-1:0]      m_data;
    int                   m_last_gnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_gnt();
        int idx;
        if (!rst_n) return -1;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (m_ptr + k) % NUM_SRC;
            if (src_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_src(input int i, input logic [RF_AWIDTH-1:0] a, input logic [XLEN-1:0] d);
        addr_p[i*RF_AWIDTH +: RF_AWIDTH] = a;
        data_p[i*XLEN +: XLEN]           = d;
    endtask

    // Compare every observable output against the model for the current cycle.
    task automatic settle_check(input string tag);
        int g;
        logic [NUM_SRC-1:0] er;
        logic es;
        #1;
        g  = exp_gnt();
        er = (g < 0) ? '0 : (NUM_SRC'(1) << g);
        es = m_busy[rs1] | m_busy[rs2] | m_busy[rd];
        chk($sformatf("%s.ready", tag), 64'(src_ready), 64'(er));
        chk($sformatf("%s.stall", tag), 64'(stall), 64'(es));
        chk($sformatf("%s.wr_req", tag), 64'(wr_req), 64'(m_wr));
        if (m_wr) begin
            chk($sformatf("%s.wr_addr", tag), 64'(wr_addr), 64'(m_addr));
            chk($sformatf("%s.wr_data", tag), 64'(wr_data), 64'(m_data));
        end
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic edge_step();
        int g;
        @(posedge clk);
        g = exp_gnt();
        if (!rst_n) begin
            m_ptr = 0; m_busy = '0; m_wr = 1'b0; m_addr = '0; m_data = '0;
            m_last_gnt = -1;
        end else begin
            if (m_wr) m_busy[m_addr] = 1'b0;
            if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
            m_last_gnt = g;
            if (g >= 0) begin
                m_addr = addr_p[g*RF_AWIDTH +: RF_AWIDTH];
                m_data = data_p[g*XLEN +: XLEN];
                m_wr   = (m_addr != 0);
                m_ptr  = (g + 1) % NUM_SRC;
            end else begin
                m_wr = 1'b0;
            end
        end
        #1;
    endtask

    task automatic tick(input string tag);
        settle_check(tag);
        edge_step();
    endtask

    initial begin
        rst_n = 1'b0; src_valid = '0; addr_p = '0; data_p = '0;
        sb_set = 1'b0; sb_addr = '0; rs1 = '0; rs2 = '0; rd = '0;
        m_ptr = 0; m_busy = '0; m_wr = 1'b0; m_addr = '0; m_data = '0; m_last_gnt = -1;
        repeat (2) @(posedge clk);
        #1;

        // Reset: ready stays low even with every source requesting.
        for (int i = 0; i < NUM_SRC; i++) set_src(i, RF_AWIDTH'(i + 1), 32'h1000 + i);
        src_valid = '1;
        settle_check("rst");
        chk("rst.ready_zero", 64'(src_ready), 64'd0);
        edge_step();
        rst_n = 1'b1; src_valid = '0;
        for (int c = 0; c < 5; c++) begin
            settle_check("idle");
            chk("idle.wr_req", 64'(wr_req), 64'd0);
            edge_step();
        end

        // Single ALU write to x5.
        set_src(0, 5'd5, 32'hDEADBEEF);
        src_valid = 3'b001;
        settle_check("alu");
        chk("alu.ready", 64'(src_ready), 64'b001);
        edge_step();
        src_valid = '0;
        settle_check("alu_t1");
        chk("alu_t1.wr_req", 64'(wr_req), 64'd1);
        chk("alu_t1.addr", 64'(wr_addr), 64'd5);
        chk("alu_t1.data", 64'(wr_data), 64'hDEADBEEF);
        edge_step();
        settle_check("alu_t2");
        chk("alu_t2.wr_req", 64'(wr_req), 64'd0);
        edge_step();

        // All three sources continuously valid from rr_ptr=0.
        rst_n = 1'b0; tick("rr_rst"); rst_n = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) set_src(i, RF_AWIDTH'(i + 1), 32'hA0 + i);
        src_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            settle_check("rr");
            chk("rr.order", 64'(src_ready), 64'(1 << (c % 3)));
            if (c > 0) begin
                chk("rr.wr_req", 64'(wr_req), 64'd1);
                chk("rr.addr", 64'(wr_addr), 64'((c - 1) % 3 + 1));
            end
            edge_step();
        end
        src_valid = '0;
        settle_check("rr_last");
        chk("rr_last.addr", 64'(wr_addr), 64'd3);
        edge_step();

        // Busy x7 held until the LSU write commits.
        sb_set = 1'b1; sb_addr = 5'd7; tick("sb7_set");
        sb_set = 1'b0; rs1 = 5'd7;
        settle_check("sb7");
        chk("sb7.stall", 64'(stall), 64'd1);
        edge_step();
        tick("sb7_wait");
        set_src(1, 5'd7, 32'h7777_0007);
        src_valid = 3'b010;
        settle_check("sb7_gnt");
        chk("sb7_gnt.ready", 64'(src_ready), 64'b010);
        edge_step();
        src_valid = '0;
        settle_check("sb7_commit");
        chk("sb7_commit.wr_req", 64'(wr_req), 64'd1);
        chk("sb7_commit.stall", 64'(stall), 64'd1);
        edge_step();
        settle_check("sb7_after");
        chk("sb7_after.stall", 64'(stall), 64'd0);
        edge_step();
        rs1 = '0;

        // Same-edge commit and set of x9: set wins.
        sb_set = 1'b1; sb_addr = 5'd9; rs2 = 5'd9; tick("sb9_set");
        sb_set = 1'b0;
        set_src(1, 5'd9, 32'h9999_0009);
        src_valid = 3'b010; tick("sb9_gnt");
        src_valid = '0; sb_set = 1'b1; sb_addr = 5'd9;
        settle_check("sb9_commit");
        chk("sb9_commit.addr", 64'(wr_addr), 64'd9);
        edge_step();
        sb_set = 1'b0;
        settle_check("sb9_held");
        chk("sb9_held.stall", 64'(stall), 64'd1);
        edge_step();
        rs2 = '0;

        // MDU write to x0 and scoreboard set of x0.
        set_src(2, 5'd0, 32'h0BAD_0000);
        src_valid = 3'b100;
        settle_check("x0");
        chk("x0.ready", 64'(src_ready), 64'b100);
        edge_step();
        src_valid = '0;
        settle_check("x0_t1");
        chk("x0_t1.wr_req", 64'(wr_req), 64'd0);
        edge_step();
        sb_set = 1'b1; sb_addr = 5'd0; tick("x0_set");
        sb_set = 1'b0; rs1 = 5'd0;
        settle_check("x0_q");
        chk("x0_q.stall", 64'(stall), 64'd0);
        edge_step();

        // Reset the cycle after a grant.
        sb_set = 1'b1; sb_addr = 5'd12; tick("mr_set");
        sb_set = 1'b0; rd = 5'd12;
        set_src(0, 5'd4, 32'h4444_0004);
        src_valid = 3'b001;
        settle_check("mr_gnt");
        chk("mr_gnt.stall", 64'(stall), 64'd1);
        edge_step();
        src_valid = '0; rst_n = 1'b0;
        tick("mr_rst");
        rst_n = 1'b1;
        settle_check("mr_after");
        chk("mr_after.wr_req", 64'(wr_req), 64'd0);
        chk("mr_after.stall", 64'(stall), 64'd0);
        edge_step();
        for (int i = 0; i < NUM_SRC; i++) set_src(i, RF_AWIDTH'(i + 20), 32'hC0 + i);
        src_valid = 3'b111;
        settle_check("mr_ptr");
        chk("mr_ptr.ready", 64'(src_ready), 64'b001);
        edge_step();
        src_valid = '0; rd = '0;

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!src_valid[i] && ($urandom % 3 == 0)) begin
                    set_src(i, RF_AWIDTH'($urandom % 16), $urandom);
                    src_valid[i] = 1'b1;
                end
            end
            sb_set  = ($urandom % 4 == 0);
            sb_addr = RF_AWIDTH'($urandom % 16);
            rs1     = RF_AWIDTH'($urandom % 16);
            rs2     = RF_AWIDTH'($urandom % 16);
            rd      = RF_AWIDTH'($urandom % 16);
            rst_n   = ($urandom % 100 != 0);
            tick("rand");
            if (m_last_gnt >= 0) src_valid[m_last_gnt] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
